// File: rtl/decade_count_checker.sv
// rtl/decade_count_checker.sv - passive cycle-accurate checker for a modulo-MODULUS loadable counter
module decade_count_checker #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10,
  parameter int ERR_W   = 8,
  parameter int MAX_ERR = 4
) (
  input  logic             CLK,
  input  logic             MR_n,
  input  logic [WIDTH-1:0] P,
  input  logic             Load,
  input  logic             Enable,
  input  logic             MR,
  input  logic [WIDTH-1:0] Q,
  input  logic             clear_stats,
  output logic [WIDTH-1:0] exp_q,
  output logic             mismatch,
  output logic             range_err,
  output logic             reset_err,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] wrap_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, FAIL = 2'd2} state_t;

  localparam logic [WIDTH:0]   MOD_W = MODULUS[WIDTH:0];
  localparam logic [WIDTH:0]   LAST  = MOD_W - 1'b1;
  localparam logic [ERR_W-1:0] MAX_E = MAX_ERR[ERR_W-1:0];

  state_t           state_r, state_nxt;
  logic [WIDTH-1:0] exp_r, exp_nxt;
  logic [ERR_W-1:0] err_r, err_nxt;
  logic [ERR_W-1:0] wrap_r, wrap_nxt;
  logic             mm_r, mm_nxt;
  logic             rng_r, rng_nxt;
  logic             rst_r, rst_nxt;
  logic             supp_r, supp_nxt;

  logic             q_eq, q_zero, q_high, p_high, at_last, err_any;
  logic [WIDTH:0]   inc_sum, inc_mod;

  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      state_r <= IDLE;
      exp_r   <= '0;
      err_r   <= '0;
      wrap_r  <= '0;
      mm_r    <= 1'b0;
      rng_r   <= 1'b0;
      rst_r   <= 1'b0;
      supp_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      exp_r   <= exp_nxt;
      err_r   <= err_nxt;
      wrap_r  <= wrap_nxt;
      mm_r    <= mm_nxt;
      rng_r   <= rng_nxt;
      rst_r   <= rst_nxt;
      supp_r  <= supp_nxt;
    end
  end

  always_comb begin
    state_nxt = state_r;
    exp_nxt   = exp_r;
    err_nxt   = err_r;
    wrap_nxt  = wrap_r;
    mm_nxt    = 1'b0;
    rng_nxt   = 1'b0;
    rst_nxt   = 1'b0;
    supp_nxt  = 1'b0;
    err_any   = 1'b0;

    // if-based compares so an unknown Q falls into the "not equal / out of range" branch
    q_eq = 1'b0;
    if (Q == exp_r) q_eq = 1'b1;
    q_zero = 1'b0;
    if (Q == '0) q_zero = 1'b1;
    q_high = 1'b1;
    if ({1'b0, Q} < MOD_W) q_high = 1'b0;

    p_high  = ({1'b0, P} >= MOD_W);
    at_last = ({1'b0, exp_r} == LAST);
    inc_sum = {1'b0, exp_r} + 1'b1;
    inc_mod = inc_sum % MOD_W;

    if (state_r == IDLE) begin
      if (MR) state_nxt = CHECK;
    end else begin
      rst_nxt  = MR & ~q_zero;
      rng_nxt  = q_high & ~supp_r;
      mm_nxt   = ~MR & ~q_eq;
      supp_nxt = ~MR & Load & p_high;
      err_any  = rst_nxt | rng_nxt | mm_nxt;

      if (MR) begin
        exp_nxt = '0;
      end else if (Load) begin
        exp_nxt = P;
      end else if (Enable) begin
        exp_nxt = inc_mod[WIDTH-1:0];
        if (at_last && !(&wrap_r)) wrap_nxt = wrap_r + 1'b1;
      end

      if (err_any && !(&err_r)) err_nxt = err_r + 1'b1;
      if (state_r == CHECK && err_any && err_nxt >= MAX_E) state_nxt = FAIL;
    end

    // clear wins over any same-edge increment or FAIL entry
    if (clear_stats) begin
      err_nxt  = '0;
      wrap_nxt = '0;
      if (state_r != IDLE) state_nxt = CHECK;
    end
  end

  assign exp_q      = exp_r;
  assign mismatch   = mm_r;
  assign range_err  = rng_r;
  assign reset_err  = rst_r;
  assign err_count  = err_r;
  assign wrap_count = wrap_r;
  assign state      = state_r;

endmodule

// File: tb/tb_decade_count_checker.sv
// tb/tb_decade_count_checker.sv - self-checking bench for decade_count_checker
module tb_decade_count_checker;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;
  localparam int ERR_W   = 8;
  localparam int MAX_ERR = 4;
  localparam int SAT     = (1 << ERR_W) - 1;

  logic             CLK = 1'b0;
  logic             MR_n = 1'b0;
  logic [WIDTH-1:0] P = '0;
  logic             Load = 1'b0;
  logic             Enable = 1'b0;
  logic             MR = 1'b0;
  logic [WIDTH-1:0] Q = '0;
  logic             clear_stats = 1'b0;
  logic [WIDTH-1:0] exp_q;
  logic             mismatch, range_err, reset_err;
  logic [ERR_W-1:0] err_count, wrap_count;
  logic [1:0]       state;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: 0 idle, 1 checking, 2 failed
  int m_state = 0, m_exp = 0, m_err = 0, m_wrap = 0;
  int m_mm = 0, m_rng = 0, m_rst = 0;
  bit m_supp = 0;

  decade_count_checker #(
    .WIDTH(WIDTH), .MODULUS(MODULUS), .ERR_W(ERR_W), .MAX_ERR(MAX_ERR)
  ) dut (
    .CLK(CLK), .MR_n(MR_n), .P(P), .Load(Load), .Enable(Enable), .MR(MR), .Q(Q),
    .clear_stats(clear_stats), .exp_q(exp_q), .mismatch(mismatch), .range_err(range_err),
    .reset_err(reset_err), .err_count(err_count), .wrap_count(wrap_count), .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".exp_q"}, int'(exp_q), m_exp);
    chk({tag, ".mismatch"}, int'(mismatch), m_mm);
    chk({tag, ".range_err"}, int'(range_err), m_rng);
    chk({tag, ".reset_err"}, int'(reset_err), m_rst);
    chk({tag, ".err_count"}, int'(err_count), m_err);
    chk({tag, ".wrap_count"}, int'(wrap_count), m_wrap);
    chk({tag, ".state"}, int'(state), m_state);
  endtask

  task automatic model_reset();
    m_state = 0; m_exp = 0; m_err = 0; m_wrap = 0;
    m_mm = 0; m_rng = 0; m_rst = 0; m_supp = 0;
  endtask

  task automatic model_edge(input int mr, input int ld, input int en, input int p, input int q,
                            input int clr);
    if (m_state == 0) begin
      m_mm = 0; m_rng = 0; m_rst = 0; m_supp = 0;
      if (mr != 0) m_state = 1;
    end else begin
      m_rst = (mr != 0 && q != 0) ? 1 : 0;
      m_rng = (q >= MODULUS && !m_supp) ? 1 : 0;
      m_mm  = (mr == 0 && q != m_exp) ? 1 : 0;
      m_supp = (mr == 0 && ld != 0 && p >= MODULUS);
      if (mr != 0) m_exp = 0;
      else if (ld != 0) m_exp = p;
      else if (en != 0) begin
        if (m_exp == MODULUS - 1 && m_wrap < SAT) m_wrap++;
        m_exp = (m_exp + 1) % MODULUS;
      end
      if ((m_rst | m_rng | m_mm) != 0 && m_err < SAT) m_err++;
      if (m_state == 1 && (m_rst | m_rng | m_mm) != 0 && m_err >= MAX_ERR) m_state = 2;
    end
    if (clr != 0) begin
      m_err = 0; m_wrap = 0;
      if (m_state != 0) m_state = 1;
    end
  endtask

  task automatic cyc(input string tag, input int mr, input int ld, input int en, input int p,
                     input int q, input int clr);
    @(negedge CLK);
    MR = mr[0]; Load = ld[0]; Enable = en[0]; P = p[WIDTH-1:0]; Q = q[WIDTH-1:0];
    clear_stats = clr[0];
    @(posedge CLK);
    model_edge(mr, ld, en, p, q, clr);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge CLK);
    #2;
    MR_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge CLK);
    MR_n = 1'b1;
  endtask

  initial begin
    int q, r;
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    @(negedge CLK);
    MR_n = 1'b1;

    // 1: reset pulse then clean count through one wrap
    cyc("t1_mr", 1, 0, 0, 0, 0, 0);
    chk("t1_to_check", int'(state), 1);
    for (int i = 0; i < 12; i++) cyc("t1_cnt", 0, 0, 1, 0, m_exp, 0);
    chk("t1_wrap", int'(wrap_count), 1);
    chk("t1_err", int'(err_count), 0);
    chk("t1_expq", int'(exp_q), 2);

    // 2: load 7 then count across the wrap
    cyc("t2_load", 0, 1, 0, 7, m_exp, 0);
    chk("t2_exp7", int'(exp_q), 7);
    for (int i = 0; i < 3; i++) cyc("t2_cnt", 0, 0, 1, 0, m_exp, 0);
    chk("t2_wrap", int'(wrap_count), 2);
    chk("t2_exp0", int'(exp_q), 0);

    // 3: single corrupted Q
    for (int i = 0; i < 3; i++) cyc("t3_cnt", 0, 0, 1, 0, m_exp, 0);
    cyc("t3_bad", 0, 0, 0, 0, 5, 0);
    chk("t3_mm", int'(mismatch), 1);
    chk("t3_err", int'(err_count), 1);
    chk("t3_state", int'(state), 1);
    cyc("t3_ok", 0, 0, 0, 0, m_exp, 0);
    chk("t3_mm_gone", int'(mismatch), 0);

    // 4: reset violations drive FAIL, clear returns to CHECK
    for (int i = 0; i < 3; i++) cyc("t4_mr", 1, 0, 0, 0, 4, 0);
    chk("t4_fail", int'(state), 2);
    chk("t4_err4", int'(err_count), 4);
    cyc("t4_mr_more", 1, 0, 0, 0, 4, 0);
    cyc("t4_clear", 0, 0, 0, 0, 5, 1);
    chk("t4_clr_err", int'(err_count), 0);
    chk("t4_clr_state", int'(state), 1);

    // 5: out-of-range load and range_err suppression
    cyc("t5_load", 0, 1, 0, 12, m_exp, 0);
    cyc("t5_supp", 0, 0, 1, 0, 12, 0);
    chk("t5_rng_supp", int'(range_err), 0);
    chk("t5_exp3", int'(exp_q), 3);
    cyc("t5_both", 0, 0, 0, 0, 12, 0);
    chk("t5_rng", int'(range_err), 1);
    chk("t5_mm", int'(mismatch), 1);
    chk("t5_err1", int'(err_count), 1);

    // 6: async reset mid-count, IDLE ignores Q until MR
    cyc("t6_load", 0, 1, 0, 6, 12, 0);
    async_reset("t6_rst");
    chk("t6_idle", int'(state), 0);
    for (int i = 0; i < 5; i++) cyc("t6_idle_q", 0, 0, 1, 0, $urandom_range(15), 0);
    chk("t6_no_err", int'(err_count), 0);
    cyc("t6_mr", 1, 0, 0, 0, 0, 0);

    // saturation of both counters
    for (int i = 0; i < SAT + 5; i++) cyc("sat_err", 1, 0, 0, 0, 4, 0);
    chk("sat_err_255", int'(err_count), SAT);
    cyc("sat_clr", 0, 0, 0, 0, m_exp, 1);
    for (int i = 0; i < MODULUS * (SAT + 2); i++) cyc("sat_wrap", 0, 0, 1, 0, m_exp, 0);
    chk("sat_wrap_255", int'(wrap_count), SAT);

    // randomized traffic against the model
    async_reset("rnd_rst");
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(99);
      q = (r < 85) ? (m_exp & 15) : $urandom_range(15);
      if ($urandom_range(299) == 0) async_reset("rnd_arst");
      else cyc("rnd", ($urandom_range(19) == 0) ? 1 : 0, ($urandom_range(9) == 0) ? 1 : 0,
               ($urandom_range(9) < 7) ? 1 : 0, $urandom_range(15), q,
               ($urandom_range(39) == 0) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
